avalon_display_master: RTL
==========================

// Module: avalon_display_master
// PURPOSE
//  Avalon-MM master (initiator) that drives the 7-segment display slave. A free-running
//  32-bit counter advances on every divided tick. The count is written to display
//  registers 0 and 1, and register 0 is read back and checked. It sits beside the
//  display slave on the same fabric as a self-test/demo traffic generator.
// PARAMETERS
//  TICK_DIV      50_000_000  clock cycles per count tick (>=8)
//  STEP          1           increment added to count per tick
//  READ_LATENCY  1           fixed slave read latency in cycles after read accept (0..3)
//  CHECK_EN      1           1 = perform read-back compare, 0 = skip RD states
// PORTS
//  clock        in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  enable       in   1   level; 1 = ticks generate bus sequences
//  m_chipselect out  1   Avalon master chipselect (asserted with write or read)
//  m_address    out  3   Avalon word address
//  m_write      out  1   Avalon write strobe
//  m_writedata  out  32  Avalon write data
//  m_read       out  1   Avalon read strobe
//  m_readdata   in   32  Avalon read data
//  m_waitrequest in  1   fabric stall; transfer accepted when strobe & !waitrequest
//  busy         out  1   sequence in progress
//  count        out  32  last count value committed to the bus
//  err          out  1   sticky read-back mismatch flag
//  err_count    out  8   mismatch counter, saturates at 8'hFF
//  overrun      out  1   sticky: tick arrived while one tick already pending
// BEHAVIOUR
//  Reset: all strobes 0, m_address 0, m_writedata 0, count 0, err 0, err_count 0,
//   overrun 0, busy 0, pending 0, divider 0, FSM IDLE. Reset mid-transfer drops strobes
//   at that edge; the slave sees an abandoned transfer.
//  Divider: counts 0..TICK_DIV-1 only while enable=1. It holds at its value when enable=0.
//   The tick is 1 cycle at wrap. next_count = count + STEP (mod 2^32).
//  Pending: a tick sets pending. A tick while pending=1 sets overrun and is dropped.
//   A tick in the same cycle as the sequence consuming pending re-sets pending.
//  FSM: IDLE -> WR0 -> WR1 -> RD0 -> RDW -> CHK -> IDLE.
//   IDLE: if pending: latch count<=next_count, clear pending, go to WR0.
//   WR0: cs=1, write=1, addr=3'd0, wdata={16'h0,count[15:0]}. Hold on waitrequest.
//   WR1: addr=3'd1, wdata={16'h0,count[31:16]}. Same handshake.
//   RD0: cs=1, read=1, addr=3'd0, held until accepted.
//    If READ_LATENCY=0, sample m_readdata in the accept cycle and go to CHK. Otherwise go to RDW.
//   RDW: wait READ_LATENCY cycles with strobes low, then sample m_readdata.
//   CHK: mismatch vs {16'h0,count[15:0]} -> err<=1, err_count+=1 (saturating). Go to IDLE.
//   CHECK_EN=0: WR1 goes directly to IDLE.
//  Strobe/data stability: address, writedata, write and read are registered outputs.
//   They are held constant while waitrequest=1. They drop in the cycle after accept.
//   Never more than one strobe high. No back-to-back same-cycle accepts.
//  busy=1 in every state except IDLE.
//  enable=0 mid-sequence: the current sequence completes. pending is retained and
//   consumed once enable returns.
//  Minimum sequence length with waitrequest=0 and READ_LATENCY=1: 5 cycles IDLE->IDLE.
// STRUCTURE
//  Package avalon_disp_pkg: FSM state enum (IDLE,WR0,WR1,RD0,RDW,CHK),
//   ADDR_REG0=3'd0, ADDR_REG1=3'd1, ADDR_REG3=3'd3.
//  Sub-module tick_divider (TICK_DIV, enable -> 1-cycle tick).
//  The FSM, pending/overrun logic and the checker stay in this module.
// TESTING
//  1 TICK_DIV=8, STEP=1, enable=1, waitrequest=0, slave model echoes writes ->
//    writes addr0=0x1 and addr1=0x0, read returns 0x1, err=0, count=1.
//  2 waitrequest high 3 cycles on WR0 -> addr/wdata/write stable for 4 cycles,
//    one write accepted, WR1 follows next cycle.
//  3 Slave model returns 0xDEAD on read ->
//    err=1, err_count=1; after 300 more bad reads err_count=8'hFF.
//  4 TICK_DIV=8, waitrequest held high 20 cycles ->
//    overrun=1, exactly one extra sequence after release, count advances by 2.
//  5 STEP=32'h0001_0000, count starts at 32'hFFFF_0000 ->
//    wraps to 0, writes addr0=0 and addr1=0.
//  6 Reset asserted during RDW -> next cycle all strobes 0, busy 0, count 0, FSM IDLE,
//    clean restart.

Source files
------------

// File: rtl/avalon_disp_pkg.sv
// Shared definitions for the 7-segment display Avalon-MM traffic generator:
// sequencer state encoding and the slave register word addresses.
package avalon_disp_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR0  = 3'd1,
    WR1  = 3'd2,
    RD0  = 3'd3,
    RDW  = 3'd4,
    CHK  = 3'd5
  } disp_state_t;

  localparam logic [2:0] ADDR_REG0 = 3'd0;
  localparam logic [2:0] ADDR_REG1 = 3'd1;
  localparam logic [2:0] ADDR_REG3 = 3'd3;

endpackage

// File: rtl/avalon_display_master_tick_divider.sv
// tick_divider: free-running 0..TICK_DIV-1 counter that advances only while
// enable is high and holds its value otherwise. tick is a one-cycle pulse in
// the cycle the counter wraps.
//   clock, reset : system clock, synchronous active-high reset
//   enable       : count enable
//   tick         : wrap pulse
module tick_divider #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] div_cnt;

  assign tick = enable && (div_cnt == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= tick ? '0 : div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/avalon_display_master.sv
// avalon_display_master: self-test traffic generator for the 7-segment display
// slave. Each divided tick advances a 32-bit count, writes its low/high halves
// to display registers 0/1, then (optionally) reads register 0 back and checks it.
//   clock, reset      : system clock, synchronous active-high reset
//   enable            : ticks generate bus sequences while high
//   m_*               : Avalon-MM master port (registered strobes/address/data)
//   busy              : sequence in progress
//   count             : last count value committed to the bus
//   err, err_count    : sticky read-back mismatch flag, saturating mismatch count
//   overrun           : sticky, a tick arrived while one was already pending
module avalon_display_master
  import avalon_disp_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter logic [31:0] STEP         = 32'd1,
  parameter int unsigned READ_LATENCY = 1,
  parameter bit          CHECK_EN     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic        m_chipselect,
  output logic [2:0]  m_address,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  output logic        busy,
  output logic [31:0] count,
  output logic        err,
  output logic [7:0]  err_count,
  output logic        overrun
);

  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  disp_state_t state, state_d;
  logic        tick;
  logic        pending;
  logic        consume;
  logic [31:0] count_d;
  logic [1:0]  lat_cnt;
  logic        lat_last;
  logic        rd_accept;
  logic        sample;
  logic [31:0] rdata_p0;
  logic        wr_d, rd_d;
  logic [2:0]  addr_d;
  logic [31:0] wdata_d;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  // A pending tick is only taken up while enabled, so a disabled master keeps it.
  assign consume   = (state == IDLE) && pending && enable;
  assign count_d   = consume ? count + STEP : count;
  assign busy      = (state != IDLE);
  assign rd_accept = m_chipselect && m_read && !m_waitrequest;
  assign lat_last  = (lat_cnt == LAT_LAST);
  assign sample    = ((state == RD0) && rd_accept && (READ_LATENCY == 0)) ||
                     ((state == RDW) && lat_last);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (consume) state_d = WR0;
      WR0:     if (!m_waitrequest) state_d = WR1;
      WR1:     if (!m_waitrequest) state_d = CHECK_EN ? RD0 : IDLE;
      RD0:     if (!m_waitrequest) state_d = (READ_LATENCY == 0) ? CHK : RDW;
      RDW:     if (lat_last) state_d = CHK;
      CHK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state and registered, so they hold
  // steady across waitrequest and drop on the edge after acceptance.
  always_comb begin
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    addr_d  = m_address;
    wdata_d = m_writedata;
    case (state_d)
      WR0: begin
        wr_d    = 1'b1;
        addr_d  = ADDR_REG0;
        wdata_d = {16'h0, count_d[15:0]};
      end
      WR1: begin
        wr_d    = 1'b1;
        addr_d  = ADDR_REG1;
        wdata_d = {16'h0, count_d[31:16]};
      end
      RD0: begin
        rd_d    = 1'b1;
        addr_d  = ADDR_REG0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      m_chipselect <= 1'b0;
      m_write      <= 1'b0;
      m_read       <= 1'b0;
      m_address    <= '0;
      m_writedata  <= '0;
      count        <= '0;
      pending      <= 1'b0;
      overrun      <= 1'b0;
      lat_cnt      <= '0;
      err          <= 1'b0;
      err_count    <= '0;
    end else begin
      m_chipselect <= wr_d | rd_d;
      m_write      <= wr_d;
      m_read       <= rd_d;
      m_address    <= addr_d;
      m_writedata  <= wdata_d;
      count        <= count_d;
      lat_cnt      <= (state == RDW) ? lat_cnt + 2'd1 : 2'd0;
      // A tick coinciding with consumption re-arms pending rather than overrunning.
      if (tick) begin
        if (pending && !consume) overrun <= 1'b1;
        pending <= 1'b1;
      end else if (consume) begin
        pending <= 1'b0;
      end
      if ((state == CHK) && (rdata_p0 != {16'h0, count[15:0]})) begin
        err       <= 1'b1;
        err_count <= sat_inc8(err_count);
      end
    end
  end

  // Read-back capture stage
  always_ff @(posedge clock) begin
    if (sample) rdata_p0 <= m_readdata;
  end

endmodule
